// File: rtl/pipe_ctrl_hazard_pkg.sv
// Shared types and constants for the pipeline control path: decoded control
// vector layout, forwarding select codes and the opcodes used by control_unit.
package pipe_ctrl_pkg;

    // Bit 7 down to bit 0, matching the control_unit output vector.
    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       memtoreg;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam int CTRL_REGWRITE_BIT = 7;
    localparam int CTRL_ALUSRC_BIT   = 6;
    localparam int CTRL_MEMWRITE_BIT = 5;
    localparam int CTRL_MEMREAD_BIT  = 4;
    localparam int CTRL_MEMTOREG_BIT = 3;
    localparam int CTRL_BRANCH_BIT   = 2;
    localparam int CTRL_ALUOP_LSB    = 0;

    localparam ctrl_t CTRL_NOP = 8'h00;
    localparam ctrl_t CTRL_R   = 8'h82;
    localparam ctrl_t CTRL_I   = 8'hC0;
    localparam ctrl_t CTRL_LW  = 8'hD8;
    localparam ctrl_t CTRL_SW  = 8'h60;
    localparam ctrl_t CTRL_BEQ = 8'h05;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // Immediate-operand ALU ops ignore the rs2 field; stores and branches read it.
    function automatic logic uses_rs2(input ctrl_t c);
        return !c.alu_src | c.mem_write | c.branch;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_if.sv
// ID-side inputs and EX/MEM/WB control outputs of the pipeline control block.
interface pipe_ctrl_hazard_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) ();
    logic                 id_valid;
    pipe_ctrl_pkg::ctrl_t id_ctrl;
    logic [RA_W-1:0]      id_rs1;
    logic [RA_W-1:0]      id_rs2;
    logic [RA_W-1:0]      id_rd;
    logic                 ex_branch_taken;

    logic                 stall;
    logic                 flush_ifid;
    logic                 ex_valid;
    pipe_ctrl_pkg::ctrl_t ex_ctrl;
    logic [RA_W-1:0]      ex_rd;
    logic [1:0]           fwd_a;
    logic [1:0]           fwd_b;
    logic                 mem_valid;
    pipe_ctrl_pkg::ctrl_t mem_ctrl;
    logic [RA_W-1:0]      mem_rd;
    logic                 wb_reg_write;
    logic                 wb_memtoreg;
    logic [RA_W-1:0]      wb_rd;
    logic [CNT_W-1:0]     bubble_cnt;

    modport slave (
        input  id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_branch_taken,
        output stall, flush_ifid, ex_valid, ex_ctrl, ex_rd, fwd_a, fwd_b,
               mem_valid, mem_ctrl, mem_rd, wb_reg_write, wb_memtoreg, wb_rd, bubble_cnt
    );

    modport master (
        output id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_branch_taken,
        input  stall, flush_ifid, ex_valid, ex_ctrl, ex_rd, fwd_a, fwd_b,
               mem_valid, mem_ctrl, mem_rd, wb_reg_write, wb_memtoreg, wb_rd, bubble_cnt
    );
endinterface

// File: rtl/pipe_ctrl_hazard_hazard_detect.sv
// Combinational load-use and taken-branch detection; decides whether the
// next EX entry is a bubble.
module hazard_detect #(
    parameter int RA_W = 5
) (
    input  logic            id_valid,
    input  logic            id_uses_rs2,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            ex_valid,
    input  logic            ex_mem_read,
    input  logic            ex_branch,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_branch_taken,
    output logic            stall,
    output logic            flush_ifid,
    output logic            bubble
);
    logic load_use;

    always_comb begin
        load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                   ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
        flush_ifid = ex_valid && ex_branch && ex_branch_taken;
        // The ID instruction is squashed on a flush, so there is nothing left to stall.
        stall  = load_use && !flush_ifid;
        bubble = load_use || flush_ifid;
    end
endmodule

// File: rtl/pipe_ctrl_hazard.sv
// Carries decoded control through EX/MEM/WB, inserts bubbles for load-use and
// taken branches, selects EX operand forwarding and counts bubbles.
module pipe_ctrl_hazard
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_ctrl_hazard_if.slave bus
);
    logic            ex_valid_q, ex_valid_d;
    ctrl_t           ex_ctrl_q, ex_ctrl_d;
    logic [RA_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [RA_W-1:0] ex_rs2_q, ex_rs2_d;
    logic [RA_W-1:0] ex_rd_q, ex_rd_d;
    logic            mem_valid_q, mem_valid_d;
    ctrl_t           mem_ctrl_q, mem_ctrl_d;
    logic [RA_W-1:0] mem_rd_q, mem_rd_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_regwrite_q, wb_regwrite_d;
    logic            wb_memtoreg_q, wb_memtoreg_d;
    logic [RA_W-1:0] wb_rd_q, wb_rd_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic stall, flush_ifid, bubble;
    logic wb_reg_write;
    logic [1:0][RA_W-1:0] ex_rs;
    logic [1:0][1:0]      fwd_sel;

    hazard_detect #(.RA_W(RA_W)) u_hazard (
        .id_valid        (bus.id_valid),
        .id_uses_rs2     (uses_rs2(bus.id_ctrl)),
        .id_rs1          (bus.id_rs1),
        .id_rs2          (bus.id_rs2),
        .ex_valid        (ex_valid_q),
        .ex_mem_read     (ex_ctrl_q.mem_read),
        .ex_branch       (ex_ctrl_q.branch),
        .ex_rd           (ex_rd_q),
        .ex_branch_taken (bus.ex_branch_taken),
        .stall           (stall),
        .flush_ifid      (flush_ifid),
        .bubble          (bubble)
    );

    always_comb begin
        ex_valid_d = bus.id_valid;
        ex_ctrl_d  = bus.id_ctrl;
        ex_rs1_d   = bus.id_rs1;
        ex_rs2_d   = bus.id_rs2;
        ex_rd_d    = bus.id_rd;
        if (bubble) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_NOP;
            ex_rs1_d   = '0;
            ex_rs2_d   = '0;
            ex_rd_d    = '0;
        end
        mem_valid_d   = ex_valid_q;
        mem_ctrl_d    = ex_ctrl_q;
        mem_rd_d      = ex_rd_q;
        wb_valid_d    = mem_valid_q;
        wb_regwrite_d = mem_ctrl_q.reg_write;
        wb_memtoreg_d = mem_ctrl_q.memtoreg;
        wb_rd_d       = mem_rd_q;
        bubble_cnt_d  = bubble_cnt_q;
        if (bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_ctrl_q     <= CTRL_NOP;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            mem_valid_q   <= 1'b0;
            mem_ctrl_q    <= CTRL_NOP;
            mem_rd_q      <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_rd_q       <= '0;
            bubble_cnt_q  <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            mem_valid_q   <= mem_valid_d;
            mem_ctrl_q    <= mem_ctrl_d;
            mem_rd_q      <= mem_rd_d;
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_rd_q       <= wb_rd_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

    // x0 is hardwired, so a write to it is never visible and never forwarded.
    assign wb_reg_write = wb_valid_q && wb_regwrite_q && (wb_rd_q != '0);
    assign ex_rs        = {ex_rs2_q, ex_rs1_q};

    // Index 0 selects operand A (rs1), index 1 operand B (rs2); the younger MEM result wins.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign fwd_sel[gi] =
            (mem_valid_q && mem_ctrl_q.reg_write && (mem_rd_q != '0) && (mem_rd_q == ex_rs[gi])) ? FWD_MEM :
            (wb_reg_write && (wb_rd_q == ex_rs[gi]))                                             ? FWD_WB  :
                                                                                                   FWD_REG;
    end

    assign bus.stall        = stall;
    assign bus.flush_ifid   = flush_ifid;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_ctrl      = ex_ctrl_q;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.fwd_a        = fwd_sel[0];
    assign bus.fwd_b        = fwd_sel[1];
    assign bus.mem_valid    = mem_valid_q;
    assign bus.mem_ctrl     = mem_ctrl_q;
    assign bus.mem_rd       = mem_rd_q;
    assign bus.wb_reg_write = wb_reg_write;
    assign bus.wb_memtoreg  = wb_memtoreg_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.bubble_cnt   = bubble_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Directed bench for pipe_ctrl_hazard: the driver pushes the hand-computed
// expectation for each cycle, a monitor pops and compares at the falling edge.
module tb_pipe_ctrl_hazard;
    import pipe_ctrl_pkg::*;

    localparam int K_ST = 1, K_FL = 2, K_EXV = 4, K_MEMV = 8, K_FA = 16, K_FB = 32;
    localparam int K_WB = 64, K_CNT = 128, K_CNT2 = 256;
    localparam int K_ALL = 255;
    localparam ctrl_t CTRL_LDBR = 8'hDC;   // load with the branch bit also set

    typedef struct {
        string      nm;
        int         care;
        logic       st, fl, exv, memv, wbrw;
        logic [1:0] fa, fb;
        int         cnt;
        int         cnt2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_hazard_if #(.RA_W(5), .CNT_W(16)) bus1 ();
    pipe_ctrl_hazard_if #(.RA_W(5), .CNT_W(2))  bus2 ();

    pipe_ctrl_hazard #(.RA_W(5), .CNT_W(16)) dut     (.clk(clk), .rst_n(rst_n), .bus(bus1));
    pipe_ctrl_hazard #(.RA_W(5), .CNT_W(2))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus2));

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0h expected %0h", nm, fld, got, exp);
        end else begin
            $display("ok   %s %s = %0h", nm, fld, got);
        end
    endtask

    task automatic cyc(input logic rs, input logic v, input ctrl_t c, input int r1, input int r2,
                       input int rd, input logic tk, input string nm, input int care,
                       input logic st, input logic fl, input logic exv, input logic memv,
                       input logic [1:0] fa, input logic [1:0] fb, input logic wbrw, input int cnt);
        exp_t e;
        @(posedge clk); #1;
        rst_n                = rs;
        bus1.id_valid        = v;
        bus1.id_ctrl         = c;
        bus1.id_rs1          = 5'(r1);
        bus1.id_rs2          = 5'(r2);
        bus1.id_rd           = 5'(rd);
        bus1.ex_branch_taken = tk;
        e.nm = nm; e.care = care; e.st = st; e.fl = fl; e.exv = exv; e.memv = memv;
        e.fa = fa; e.fb = fb; e.wbrw = wbrw; e.cnt = cnt; e.cnt2 = 0;
        sb_q.push_back(e);
    endtask

    // Back-to-back taken branches into the 2-bit-counter instance.
    task automatic cyc2(input string nm, input int cnt2);
        exp_t e;
        @(posedge clk); #1;
        bus2.id_valid        = 1'b1;
        bus2.id_ctrl         = CTRL_BEQ;
        bus2.id_rs1          = 5'd1;
        bus2.id_rs2          = 5'd2;
        bus2.id_rd           = 5'd0;
        bus2.ex_branch_taken = 1'b1;
        e.nm = nm; e.care = K_CNT2; e.st = 0; e.fl = 0; e.exv = 0; e.memv = 0;
        e.fa = 0; e.fb = 0; e.wbrw = 0; e.cnt = 0; e.cnt2 = cnt2;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if ((e.care & K_ST)   != 0) chk(e.nm, "stall",        32'(bus1.stall),        32'(e.st));
                if ((e.care & K_FL)   != 0) chk(e.nm, "flush_ifid",   32'(bus1.flush_ifid),   32'(e.fl));
                if ((e.care & K_EXV)  != 0) chk(e.nm, "ex_valid",     32'(bus1.ex_valid),     32'(e.exv));
                if ((e.care & K_MEMV) != 0) chk(e.nm, "mem_valid",    32'(bus1.mem_valid),    32'(e.memv));
                if ((e.care & K_FA)   != 0) chk(e.nm, "fwd_a",        32'(bus1.fwd_a),        32'(e.fa));
                if ((e.care & K_FB)   != 0) chk(e.nm, "fwd_b",        32'(bus1.fwd_b),        32'(e.fb));
                if ((e.care & K_WB)   != 0) chk(e.nm, "wb_reg_write", 32'(bus1.wb_reg_write), 32'(e.wbrw));
                if ((e.care & K_CNT)  != 0) chk(e.nm, "bubble_cnt",   32'(bus1.bubble_cnt),   32'(e.cnt));
                if ((e.care & K_CNT2) != 0) chk(e.nm, "bubble_cnt_w2", 32'(bus2.bubble_cnt),  32'(e.cnt2));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bus1.id_valid = 1'b0; bus1.id_ctrl = CTRL_NOP; bus1.id_rs1 = '0; bus1.id_rs2 = '0;
        bus1.id_rd = '0; bus1.ex_branch_taken = 1'b0;
        bus2.id_valid = 1'b0; bus2.id_ctrl = CTRL_NOP; bus2.id_rs1 = '0; bus2.id_rs2 = '0;
        bus2.id_rd = '0; bus2.ex_branch_taken = 1'b0;
        repeat (2) @(posedge clk);

        cyc(0, 0, CTRL_NOP, 0, 0, 0, 0, "reset_init", K_ALL, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        // load-use: lw x5 then add x6,x5,x1
        cyc(1, 1, CTRL_LW, 2, 0, 5, 0, "lu_issue_lw", K_ST|K_EXV|K_CNT, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, CTRL_R, 5, 1, 6, 0, "lu_stall", K_ST|K_FL|K_EXV|K_CNT, 1, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, CTRL_R, 5, 1, 6, 0, "lu_bubble", K_ST|K_EXV|K_CNT, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, CTRL_NOP, 0, 0, 0, 0, "lu_fwd_wb", K_ST|K_EXV|K_FA|K_FB|K_WB|K_CNT, 0, 0, 1, 0, 2'b01, 2'b00, 1, 1);
        // back-to-back dependency forwards from MEM
        cyc(1, 1, CTRL_R, 1, 2, 3, 0, "fw_issue_add3", K_EXV|K_FA|K_FB, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc(1, 1, CTRL_R, 3, 3, 4, 0, "fw_add3_in_ex", K_ST|K_EXV|K_FA|K_FB|K_WB, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0);
        cyc(1, 0, CTRL_NOP, 0, 0, 0, 0, "fw_mem_mem", K_ST|K_EXV|K_FA|K_FB|K_WB, 0, 0, 1, 0, 2'b10, 2'b10, 0, 0);
        // one independent instruction between -> forwards from WB
        cyc(1, 1, CTRL_R, 1, 2, 3, 0, "fw2_issue_add3", K_EXV|K_WB, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, CTRL_R, 1, 1, 8, 0, "fw2_issue_indep", K_EXV|K_FA|K_FB, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0);
        cyc(1, 1, CTRL_R, 3, 3, 4, 0, "fw2_indep_in_ex", K_EXV|K_FA|K_FB, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0);
        cyc(1, 0, CTRL_NOP, 0, 0, 0, 0, "fw_wb_wb", K_ST|K_EXV|K_FA|K_FB|K_WB, 0, 0, 1, 0, 2'b01, 2'b01, 1, 0);
        // two writers of x3 in MEM and WB: MEM wins
        cyc(1, 1, CTRL_R, 1, 2, 3, 0, "pr_issue_a", K_WB, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, CTRL_R, 1, 2, 3, 0, "pr_issue_b", K_EXV, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, CTRL_R, 3, 3, 4, 0, "pr_sub_issue", K_FA|K_FB|K_WB, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc(1, 0, CTRL_NOP, 0, 0, 0, 0, "pr_mem_beats_wb", K_EXV|K_FA|K_FB|K_WB, 0, 0, 1, 0, 2'b10, 2'b10, 1, 0);
        // taken branch flush, then taken=1 with a non-branch in EX
        cyc(1, 1, CTRL_BEQ, 1, 2, 0, 0, "br_issue", K_FL|K_EXV, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, CTRL_R, 1, 2, 6, 1, "br_flush", K_ST|K_FL|K_EXV|K_CNT, 0, 1, 1, 0, 0, 0, 0, 1);
        cyc(1, 0, CTRL_NOP, 0, 0, 0, 0, "br_bubble", K_FL|K_EXV|K_CNT, 0, 0, 0, 0, 0, 0, 0, 2);
        cyc(1, 1, CTRL_R, 1, 2, 7, 0, "br_issue_add", K_FL|K_EXV, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, CTRL_NOP, 0, 0, 0, 1, "br_taken_nonbranch", K_ST|K_FL|K_EXV|K_CNT, 0, 0, 1, 0, 0, 0, 0, 2);
        cyc(1, 0, CTRL_NOP, 0, 0, 0, 0, "br_idle", K_EXV|K_CNT, 0, 0, 0, 0, 0, 0, 0, 2);
        // x0 destination: no stall, no forward, no write
        cyc(1, 1, CTRL_LW, 2, 0, 0, 0, "x0_issue_lw", K_WB, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, CTRL_R, 0, 0, 6, 0, "x0_no_stall", K_ST|K_EXV|K_CNT, 0, 0, 1, 0, 0, 0, 0, 2);
        cyc(1, 0, CTRL_NOP, 0, 0, 0, 0, "x0_no_fwd", K_ST|K_EXV|K_MEMV|K_FA|K_FB, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);
        cyc(1, 0, CTRL_NOP, 0, 0, 0, 0, "x0_no_wb_write", K_WB|K_FA|K_FB, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        // immediate op ignores rs2; store uses rs2
        cyc(1, 1, CTRL_LW, 2, 0, 5, 0, "imm_issue_lw", K_WB, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, CTRL_I, 1, 5, 7, 0, "imm_rs2_ignored", K_ST|K_EXV|K_CNT, 0, 0, 1, 0, 0, 0, 0, 2);
        cyc(1, 1, CTRL_LW, 2, 0, 5, 0, "sw_issue_lw", K_ST|K_EXV, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, CTRL_SW, 1, 5, 0, 0, "sw_stall_rs2", K_ST|K_EXV|K_CNT, 1, 0, 1, 0, 0, 0, 0, 2);
        cyc(1, 1, CTRL_SW, 1, 5, 0, 0, "sw_bubble", K_ST|K_EXV|K_CNT, 0, 0, 0, 0, 0, 0, 0, 3);
        cyc(1, 0, CTRL_NOP, 0, 0, 0, 0, "sw_fwd_b_wb", K_EXV|K_FA|K_FB|K_WB, 0, 0, 1, 0, 2'b00, 2'b01, 1, 0);
        // load-use and taken branch in the same cycle: flush wins, one bubble
        cyc(1, 1, CTRL_LDBR, 1, 2, 5, 0, "mix_issue", K_ST|K_FL, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, CTRL_R, 5, 1, 6, 1, "mix_flush_wins", K_ST|K_FL|K_EXV|K_CNT, 0, 1, 1, 0, 0, 0, 0, 3);
        cyc(1, 0, CTRL_NOP, 0, 0, 0, 0, "mix_one_bubble", K_ST|K_FL|K_EXV|K_CNT, 0, 0, 0, 0, 0, 0, 0, 4);
        cyc(1, 0, CTRL_NOP, 0, 0, 0, 0, "mix_count_hold", K_EXV|K_CNT, 0, 0, 0, 0, 0, 0, 0, 4);
        // async reset with three valid stages and a pending load-use
        cyc(1, 0, CTRL_NOP, 0, 0, 0, 0, "rs_idle", K_CNT, 0, 0, 0, 0, 0, 0, 0, 4);
        cyc(1, 1, CTRL_R, 2, 3, 1, 0, "rs_issue1", K_EXV, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, CTRL_R, 2, 3, 2, 0, "rs_issue2", K_EXV, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, CTRL_LW, 2, 0, 5, 0, "rs_two_valid", K_EXV|K_MEMV, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, CTRL_R, 5, 1, 6, 0, "rs_async_clear", K_ALL, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        cyc(0, 0, CTRL_NOP, 0, 0, 0, 0, "rs_held", K_EXV|K_MEMV|K_WB|K_CNT, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, CTRL_R, 5, 1, 6, 0, "rs_first_cycle", K_ST|K_EXV|K_MEMV|K_CNT, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, CTRL_NOP, 0, 0, 0, 0, "rs_pipe_restart", K_ST|K_EXV|K_FA|K_CNT, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0);

        // saturation with CNT_W=2: five flush bubbles, counter stops at 3
        cyc2("sat_c01", 0);
        cyc2("sat_c02", 0);
        cyc2("sat_c03", 1);
        cyc2("sat_c04", 1);
        cyc2("sat_c05", 2);
        cyc2("sat_c06", 2);
        cyc2("sat_c07", 3);
        cyc2("sat_c08", 3);
        cyc2("sat_c09", 3);
        cyc2("sat_c10", 3);
        cyc2("sat_c11", 3);
        cyc2("sat_c12", 3);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard", "drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
